// File: rtl/matrix_alu.sv
// 4x4 matrix ALU: add, sub, transpose, scale and sequential multiply on 16-bit elements.
// Optional macro MATRIX_ALU_SATURATE_EN selects signed saturating arithmetic.
module matrix_alu #(
    parameter int ELEM_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                start,
    input  logic [2:0]          opcode,
    input  logic [16*ELEM_W-1:0] operandA,
    input  logic [16*ELEM_W-1:0] operandB,
    output logic [16*ELEM_W-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int MW = 16 * ELEM_W;
    localparam int XW = 2 * ELEM_W + 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_TRN = 3'b010;
    localparam logic [2:0] OP_SCL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [MW-1:0]     a_q, a_d;
    logic [MW-1:0]     b_q, b_d;
    logic [MW-1:0]     acc_q, acc_d;
    logic [MW-1:0]     result_q, result_d;
    logic [3:0]        k_q, k_d;
    logic              err_q, err_d;

    logic [MW-1:0]     ew;
    logic [MW-1:0]     acc_next;
    logic signed [XW-1:0] mac;

    function automatic logic [ELEM_W-1:0] get(input logic [MW-1:0] m, input int idx);
        return m[MW-1-ELEM_W*idx -: ELEM_W];
    endfunction

    function automatic logic signed [XW-1:0] ext(input logic [ELEM_W-1:0] x);
`ifdef MATRIX_ALU_SATURATE_EN
        return {{(XW-ELEM_W){x[ELEM_W-1]}}, x};
`else
        return {{(XW-ELEM_W){1'b0}}, x};
`endif
    endfunction

    // Final per-element narrowing: clamp in the signed build, wrap otherwise.
    function automatic logic [ELEM_W-1:0] fit(input logic signed [XW-1:0] v);
`ifdef MATRIX_ALU_SATURATE_EN
        if (v > XW'(2**(ELEM_W-1) - 1))
            return {1'b0, {(ELEM_W-1){1'b1}}};
        else if (v < -XW'(2**(ELEM_W-1)))
            return {1'b1, {(ELEM_W-1){1'b0}}};
        else
            return v[ELEM_W-1:0];
`else
        return v[ELEM_W-1:0];
`endif
    endfunction

    always_comb begin
        ew = '0;
        for (int i = 0; i < 16; i++) begin
            case (op_q)
                OP_ADD: ew[MW-1-ELEM_W*i -: ELEM_W] =
                    fit(ext(get(a_q, i)) + ext(get(b_q, i)));
                OP_SUB: ew[MW-1-ELEM_W*i -: ELEM_W] =
                    fit(ext(get(a_q, i)) - ext(get(b_q, i)));
                OP_TRN: ew[MW-1-ELEM_W*i -: ELEM_W] =
                    get(a_q, 4 * (i % 4) + i / 4);
                OP_SCL: ew[MW-1-ELEM_W*i -: ELEM_W] =
                    fit(ext(get(a_q, i)) * ext(b_q[ELEM_W-1:0]));
                default: ;
            endcase
        end
    end

    always_comb begin
        mac = '0;
        for (int j = 0; j < 4; j++) begin
            mac = mac + ext(get(a_q, 4 * int'(k_q[3:2]) + j))
                      * ext(get(b_q, 4 * j + int'(k_q[1:0])));
        end
        acc_next = acc_q;
        acc_next[MW-1-ELEM_W*int'(k_q) -: ELEM_W] = fit(mac);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    a_d     = operandA;
                    b_d     = operandB;
                    k_d     = '0;
                    err_d   = (opcode > OP_MUL);
                    state_d = LOAD;
                end
            end
            LOAD: state_d = EXEC;
            EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d = acc_next;
                    k_d   = k_q + 4'd1;
                    if (k_q == 4'(MUL_CYCLES - 1)) begin
                        result_d = acc_next;
                        state_d  = DONE;
                    end
                end else begin
                    if (!err_q)
                        result_d = ew;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == LOAD) || (state_q == EXEC);
    assign done   = (state_q == DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_matrix_alu.sv
// Directed testbench for matrix_alu with immediate-assertion checks.
// Honours MATRIX_ALU_SATURATE_EN for the overflow expectation.
module tb_matrix_alu;

    logic         Clk;
    logic         nReset;
    logic         start;
    logic [2:0]   opcode;
    logic [255:0] operandA;
    logic [255:0] operandB;
    logic [255:0] result;
    logic         busy;
    logic         done;
    logic         err;

    int tests;
    int fails;

    matrix_alu dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .start    (start),
        .opcode   (opcode),
        .operandA (operandA),
        .operandB (operandB),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [255:0] MAT_A =
        256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
    localparam logic [255:0] MAT_B =
        256'h0020_001f_001e_001d_001c_001b_001a_0019_0018_0017_0016_0015_0014_0013_0012_0011;
    localparam logic [255:0] ALL21 = {16{16'h0021}};
    localparam logic [255:0] TRN_A =
        256'h0001_0005_0009_000d_0002_0006_000a_000e_0003_0007_000b_000f_0004_0008_000c_0010;
    localparam logic [255:0] SCL_A =
        256'h000a_0014_001e_0028_0032_003c_0046_0050_005a_0064_006e_0078_0082_008c_0096_00a0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise start for one cycle at a falling edge; returns at the falling edge after acceptance.
    task automatic op_start(input logic [2:0] opc, input logic [255:0] a, input logic [255:0] b);
        opcode   = opc;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
    endtask

    // n counts falling edges since the accepting edge; poke re-raises start while busy.
    task automatic wait_done(input int maxc, input int poke, output int n);
        n = 1;
        while (done !== 1'b1 && n < maxc) begin
            start = (n == poke);
            if (n == poke) operandA = '1;
            @(negedge Clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    int n;
    int cnt;
    logic [255:0] ovf_a;
    logic [255:0] ovf_b;
    logic [15:0]  ovf_exp;
    logic [255:0] r;

    initial begin
        tests    = 0;
        fails    = 0;
        nReset   = 1'b0;
        start    = 1'b0;
        opcode   = '0;
        operandA = '0;
        operandB = '0;
        #12;
        check("rst_result", result, '0);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        @(negedge Clk);
        nReset = 1'b1;
        @(negedge Clk);

        // add
        op_start(3'b000, MAT_A, MAT_B);
        check("add_busy1", 256'(busy), 256'(1));
        @(negedge Clk);
        check("add_busy2", 256'(busy), 256'(1));
        check("add_nodone", 256'(done), 256'(0));
        @(negedge Clk);
        check("add_done", 256'(done), 256'(1));
        check("add_busy_off", 256'(busy), 256'(0));
        check("add_err", 256'(err), 256'(0));
        check("add_result", result, ALL21);
        @(negedge Clk);
        check("add_done_pulse", 256'(done), 256'(0));

        // illegal opcode keeps previous result
        op_start(3'b111, MAT_B, MAT_A);
        wait_done(40, 0, n);
        check("ill_lat", 256'(n), 256'(3));
        check("ill_err", 256'(err), 256'(1));
        check("ill_result", result, ALL21);
        @(negedge Clk);

        // sub, also clears err
        op_start(3'b001, MAT_A, MAT_B);
        wait_done(40, 0, n);
        check("sub_lat", 256'(n), 256'(3));
        check("sub_err_clr", 256'(err), 256'(0));
        r = result;
        check("sub_e00", 256'(r[255:240]), 256'(16'hffe1));
        check("sub_e33", 256'(r[15:0]), 256'(16'hffff));
        @(negedge Clk);

        // transpose
        op_start(3'b010, MAT_A, MAT_B);
        wait_done(40, 0, n);
        check("trn_result", result, TRN_A);
        @(negedge Clk);

        // scale by 10
        op_start(3'b011, MAT_A, 256'd10);
        wait_done(40, 0, n);
        check("scl_result", result, SCL_A);
        @(negedge Clk);

        // multiply, with a start pulse and operand change while busy
        op_start(3'b100, MAT_A, MAT_B);
        wait_done(60, 5, n);
        check("mul_lat", 256'(n), 256'(18));
        r = result;
        check("mul_e00", 256'(r[255:240]), 256'(16'h00f0));
        check("mul_e01", 256'(r[239:224]), 256'(16'h00e6));
        check("mul_e33", 256'(r[15:0]), 256'(16'h0522));
        count_dones(25, cnt);
        check("mul_single_done", 256'(cnt), 256'(0));
        check("mul_hold", 256'(result[255:240]), 256'(16'h00f0));

        // reset in the middle of a multiply
        op_start(3'b100, MAT_A, MAT_B);
        repeat (7) @(negedge Clk);
        check("abort_busy_pre", 256'(busy), 256'(1));
        nReset = 1'b0;
        #1;
        check("abort_result", result, '0);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        @(negedge Clk);
        nReset = 1'b1;
        count_dones(25, cnt);
        check("abort_no_done", 256'(cnt), 256'(0));
        op_start(3'b000, MAT_A, MAT_B);
        wait_done(40, 0, n);
        check("post_abort_lat", 256'(n), 256'(3));
        check("post_abort_res", result, ALL21);
        @(negedge Clk);

        // overflow on element (0,0)
        ovf_a = '0;
        ovf_b = '0;
        ovf_a[255:240] = 16'h7fff;
        ovf_b[255:240] = 16'h0001;
`ifdef MATRIX_ALU_SATURATE_EN
        ovf_exp = 16'h7fff;
`else
        ovf_exp = 16'h8000;
`endif
        op_start(3'b000, ovf_a, ovf_b);
        wait_done(40, 0, n);
        check("ovf_e00", 256'(result[255:240]), 256'(ovf_exp));
        check("ovf_e01", 256'(result[239:224]), 256'(0));
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
